// File: rtl/rv_pkg.sv
// Shared RV32I front-end constants, opcode encodings and the fetch state type.
package rv_pkg;

   localparam logic [31:0] RESET_PC   = 32'h0100_0000;
   localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
   localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

   localparam logic [6:0] OP_BRANCH = 7'b110_0011;
   localparam logic [6:0] OP_JAL    = 7'b110_1111;
   localparam logic [6:0] OP_JALR   = 7'b110_0111;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   // Instructions are word aligned; the low two address bits are dropped.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-side bus: instruction-memory port plus the F/D register seen by decode.
interface fetch_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] d_pc;
   logic [31:0] d_insn;
   logic        d_valid;

   modport master (
      output imem_addr,
      input  imem_data,
      output d_pc,
      output d_insn,
      output d_valid
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      input  d_pc,
      input  d_insn,
      input  d_valid
   );
endinterface

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register: reset > flush (bubble at the new PC) > hold > load.
module fd_reg
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSN = rv_pkg::NOP_INSN
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_insn,
   input  logic        load_valid,
   output logic [31:0] d_pc,
   output logic [31:0] d_insn,
   output logic        d_valid
);

   always_ff @(posedge clock) begin
      if (reset) begin
         d_pc    <= RESET_PC;
         d_insn  <= NOP_INSN;
         d_valid <= 1'b0;
      end else if (flush) begin
         d_pc    <= flush_pc;
         d_insn  <= NOP_INSN;
         d_valid <= 1'b0;
      end else if (!hold) begin
         d_pc    <= load_pc;
         d_insn  <= load_insn;
         d_valid <= load_valid;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the fetch PC, the RUN/HALTED machine and the event counters.
module fetch_stage
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = rv_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSN   = rv_pkg::NOP_INSN,
   parameter logic [31:0] ECALL_INSN = rv_pkg::ECALL_INSN
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          stall,
   input  logic          redirect,
   input  logic [31:0]   redirect_target,
   fetch_stage_if.master fbus,
   output logic          x_flush,
   output logic          halted,
   output logic          misalign_err,
   output logic [31:0]   fetch_count,
   output logic [31:0]   flush_count
);

   logic [31:0]  pc_f;
   fetch_state_e state;
   logic [31:0]  target_aligned;
   logic         is_ecall;
   logic         running;
   logic [31:0]  d_pc_w;
   logic [31:0]  d_insn_w;
   logic         d_valid_w;

   assign target_aligned = align_word(redirect_target);
   assign is_ecall       = (fbus.imem_data == ECALL_INSN);
   assign running        = (state == RUN);
   assign fbus.imem_addr = pc_f;
   assign x_flush        = redirect;

   // Priority per edge: reset > redirect > stall > normal fetch.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_f         <= RESET_PC;
         state        <= RUN;
         halted       <= 1'b0;
         misalign_err <= 1'b0;
         fetch_count  <= '0;
         flush_count  <= '0;
      end else if (redirect) begin
         pc_f        <= target_aligned;
         state       <= RUN;
         halted      <= 1'b0;
         flush_count <= flush_count + 32'd1;
         if (redirect_target[1:0] != 2'b00) begin
            misalign_err <= 1'b1;
         end
      end else if (!stall) begin
         case (state)
            RUN: begin
               fetch_count <= fetch_count + 32'd1;
               if (is_ecall) begin
                  // PC parks on the ECALL so a later redirect is the only way out.
                  state  <= HALTED;
                  halted <= 1'b1;
               end else begin
                  pc_f <= pc_f + 32'd4;
               end
            end
            HALTED: begin
               pc_f <= pc_f;
            end
            default: begin
               state  <= RUN;
               halted <= 1'b0;
            end
         endcase
      end
   end

   fd_reg #(
      .RESET_PC (RESET_PC),
      .NOP_INSN (NOP_INSN)
   ) u_fd_reg (
      .clock      (clock),
      .reset      (reset),
      .hold       (stall),
      .flush      (redirect),
      .flush_pc   (target_aligned),
      .load_pc    (pc_f),
      .load_insn  (running ? fbus.imem_data : NOP_INSN),
      .load_valid (running),
      .d_pc       (d_pc_w),
      .d_insn     (d_insn_w),
      .d_valid    (d_valid_w)
   );

   assign fbus.d_pc    = d_pc_w;
   assign fbus.d_insn  = d_insn_w;
   assign fbus.d_valid = d_valid_w;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model queues per-edge expectations.
module tb_fetch_stage;
   import rv_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        x_flush;
   logic        halted;
   logic        misalign_err;
   logic [31:0] fetch_count;
   logic [31:0] flush_count;
   logic        ecall_en = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   fetch_stage_if fbus ();

   fetch_stage dut (
      .clock           (clock),
      .reset           (reset),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .fbus            (fbus.master),
      .x_flush         (x_flush),
      .halted          (halted),
      .misalign_err    (misalign_err),
      .fetch_count     (fetch_count),
      .flush_count     (flush_count)
   );

   always #5 clock = ~clock;

   // Instruction memory: addi x1,x0,<addr bits> everywhere, ECALL at 01000010 when enabled.
   function automatic logic [31:0] imem_fn(input logic [31:0] a, input logic en);
      if (en && a == 32'h0100_0010) return ECALL_INSN;
      return {a[13:2], 20'h00093};
   endfunction

   always_comb begin
      fbus.imem_data = {fbus.imem_addr[13:2], 20'h00093};
      if (ecall_en && fbus.imem_addr == 32'h0100_0010) fbus.imem_data = ECALL_INSN;
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] dpc;
      logic [31:0] dinsn;
      logic        dvalid;
      logic        halted;
      logic        mis;
      logic [31:0] fc;
      logic [31:0] flc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_pc = RESET_PC;
   logic [31:0] m_dpc = RESET_PC;
   logic [31:0] m_dinsn = NOP_INSN;
   logic        m_dvalid = 1'b0;
   logic        m_halted = 1'b0;
   logic        m_mis = 1'b0;
   logic [31:0] m_fc = '0;
   logic [31:0] m_flc = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // One clock edge: drive inputs, check combinational outputs, queue the model's next state, compare.
   task automatic step(input logic rs, input logic st, input logic rd, input logic [31:0] tg,
                       input logic chk_comb);
      exp_t        e;
      logic [31:0] ins;
      reset = rs; stall = st; redirect = rd; redirect_target = tg;
      #1;
      if (chk_comb) begin
         check("imem_addr", fbus.imem_addr, m_pc);
         check("x_flush", {31'b0, x_flush}, {31'b0, rd});
      end
      if (rs) begin
         m_pc = RESET_PC; m_dpc = RESET_PC; m_dinsn = NOP_INSN; m_dvalid = 1'b0;
         m_halted = 1'b0; m_mis = 1'b0; m_fc = '0; m_flc = '0;
      end else if (rd) begin
         m_pc = {tg[31:2], 2'b00}; m_dpc = m_pc; m_dinsn = NOP_INSN; m_dvalid = 1'b0;
         m_halted = 1'b0; m_flc = m_flc + 1;
         if (tg[1:0] != 2'b00) m_mis = 1'b1;
      end else if (!st) begin
         if (!m_halted) begin
            ins = imem_fn(m_pc, ecall_en);
            m_dinsn = ins; m_dpc = m_pc; m_dvalid = 1'b1; m_fc = m_fc + 1;
            if (ins == ECALL_INSN) m_halted = 1'b1;
            else m_pc = m_pc + 32'd4;
         end else begin
            m_dinsn = NOP_INSN; m_dvalid = 1'b0; m_dpc = m_pc;
         end
      end
      e = '{m_pc, m_dpc, m_dinsn, m_dvalid, m_halted, m_mis, m_fc, m_flc};
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      check("pc_f", fbus.imem_addr, e.pc);
      check("d_pc", fbus.d_pc, e.dpc);
      check("d_insn", fbus.d_insn, e.dinsn);
      check("d_valid", {31'b0, fbus.d_valid}, {31'b0, e.dvalid});
      check("halted", {31'b0, halted}, {31'b0, e.halted});
      check("misalign_err", {31'b0, misalign_err}, {31'b0, e.mis});
      check("fetch_count", fetch_count, e.fc);
      check("flush_count", flush_count, e.flc);
   endtask

   initial begin
      @(posedge clock);
      #1;
      // Reset and free-running fetch.
      step(1, 0, 0, 0, 0);
      check("rst_d_valid", {31'b0, fbus.d_valid}, 32'd0);
      check("rst_pc", fbus.imem_addr, 32'h0100_0000);
      step(0, 0, 0, 0, 1);
      check("seq_dpc0", fbus.d_pc, 32'h0100_0000);
      step(0, 0, 0, 0, 1);
      check("seq_dpc1", fbus.d_pc, 32'h0100_0004);
      // Stall three cycles at pc_f = 01000008.
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 1);
         check("stall_pc", fbus.imem_addr, 32'h0100_0008);
         check("stall_dpc", fbus.d_pc, 32'h0100_0004);
      end
      step(0, 0, 0, 0, 1);
      check("resume_dpc", fbus.d_pc, 32'h0100_0008);
      check("resume_pc", fbus.imem_addr, 32'h0100_000C);
      check("resume_fc", fetch_count, 32'd3);
      // Redirect with a simultaneous stall.
      step(0, 1, 1, 32'h0100_0100, 1);
      check("redir_insn", fbus.d_insn, NOP_INSN);
      check("redir_pc", fbus.imem_addr, 32'h0100_0100);
      check("redir_flc", flush_count, 32'd1);
      step(0, 0, 0, 0, 1);
      // ECALL halts fetch; a redirect releases it.
      ecall_en = 1'b1;
      step(0, 0, 1, 32'h0100_0010, 1);
      step(0, 0, 0, 0, 1);
      check("ecall_insn", fbus.d_insn, ECALL_INSN);
      check("ecall_halted", {31'b0, halted}, 32'd1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
      check("halt_pc", fbus.imem_addr, 32'h0100_0010);
      step(0, 1, 0, 0, 1);
      step(0, 0, 1, 32'h0100_0020, 1);
      check("unhalt", {31'b0, halted}, 32'd0);
      step(0, 0, 0, 0, 1);
      check("unhalt_dpc", fbus.d_pc, 32'h0100_0020);
      // Wrong-path ECALL fetched alongside a redirect must not halt.
      step(0, 0, 1, 32'h0100_0010, 1);
      step(0, 0, 1, 32'h0100_0010, 1);
      check("wp_ecall", {31'b0, halted}, 32'd0);
      ecall_en = 1'b0;
      // Misaligned redirect target is sticky.
      step(0, 0, 1, 32'h0100_0102, 1);
      check("mis_pc", fbus.imem_addr, 32'h0100_0100);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
      check("mis_sticky", {31'b0, misalign_err}, 32'd1);
      step(1, 0, 0, 0, 1);
      check("mis_clear", {31'b0, misalign_err}, 32'd0);
      // PC wraps past the top of the address space.
      step(0, 0, 1, 32'hFFFF_FFFC, 1);
      step(0, 0, 0, 0, 1);
      check("wrap_pc", fbus.imem_addr, 32'h0000_0000);
      // Reset while halted with nonzero counters.
      ecall_en = 1'b1;
      step(0, 0, 1, 32'h0100_0010, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check("pre_rst_halted", {31'b0, halted}, 32'd1);
      step(1, 0, 0, 0, 1);
      check("hrst_pc", fbus.imem_addr, 32'h0100_0000);
      check("hrst_halted", {31'b0, halted}, 32'd0);
      check("hrst_fc", fetch_count, 32'd0);
      check("hrst_flc", flush_count, 32'd0);
      check("hrst_valid", {31'b0, fbus.d_valid}, 32'd0);
      step(0, 0, 0, 0, 1);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Front end of the 5-stage RV32I pipeline. Owns the fetch PC and the F/D pipeline register, and drives the instruction-memory address. It supplies decode with the instruction, PC and valid bit. It honours stall from the hazard logic and redirect (taken branch/jump) from execute, squashes wrong-path instructions with NOP bubbles, and halts fetch after an ECALL.

Parameters:
RESET_PC, 32'h01000000, fetch PC after reset
NOP_INSN, 32'h00000013, bubble encoding (addi x0,x0,0)
ECALL_INSN, 32'h00000073, encoding that triggers halt

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
stall  in  1  hazard unit: hold F and D this cycle
redirect  in  1  execute stage: branch/jump taken
redirect_target  in  32  new fetch PC (ALU result)
imem_addr  out  32  instruction memory address (= fetch PC, combinational)
imem_data  in  32  instruction word, combinational read of imem_addr
d_pc  out  32  PC of instruction in decode
d_insn  out  32  instruction in decode
d_valid  out  1  decode holds a real (non-bubble) instruction
x_flush  out  1  squash D->X transfer this cycle (= redirect)
halted  out  1  fetch halted after ECALL
misalign_err  out  1  sticky: redirect target had bits[1:0] != 0
fetch_count  out  32  valid instructions delivered to decode
flush_count  out  32  redirect events

Behaviour:
- Reset values: pc_f=RESET_PC; d_pc=RESET_PC; d_insn=NOP_INSN; d_valid=0; state=RUN; halted=0; misalign_err=0; both counters 0. Reset overrides every other input, including mid-redirect and in HALTED.
- imem_addr = pc_f, combinational. The word fetched at pc_f is latched into D at the next edge, so fetch-to-decode latency is 1 cycle.
- State machine RUN / HALTED. Per-edge priority: reset > redirect > stall > normal.
- redirect=1, any state:
  - pc_f <= {redirect_target[31:2],2'b00}.
  - d_insn <= NOP_INSN; d_valid <= 0; d_pc <= redirect_target aligned.
  - state <= RUN.
  - flush_count += 1.
  - If redirect_target[1:0] != 0, set misalign_err (sticky until reset).
  - x_flush = redirect, combinational, same cycle.
  - Redirect overrides a simultaneous stall.
- stall=1, redirect=0: pc_f, d_pc, d_insn, d_valid, state and counters all hold.
- RUN, normal:
  - d_insn <= imem_data; d_pc <= pc_f; d_valid <= 1; fetch_count += 1.
  - If imem_data == ECALL_INSN: pc_f holds and state <= HALTED. The ECALL itself is delivered to D.
  - Otherwise pc_f <= pc_f + 4, wrapping mod 2^32 (32'hFFFFFFFC -> 0).
- HALTED, normal: pc_f holds; d_insn <= NOP_INSN; d_valid <= 0; fetch_count holds. halted=1 iff state==HALTED.
- An ECALL fetched in the same cycle as a redirect is wrong-path. The redirect wins and the state stays RUN.
- A redirect while HALTED returns to RUN, because the halt was speculative behind an older branch.
- Counters are 32-bit and wrap silently.

Decomposition:
- Shared package rv_pkg:
  - RESET_PC, NOP_INSN, ECALL_INSN.
  - Opcode localparams (OP_BRANCH, OP_JAL, OP_JALR).
  - Fetch state enum: RUN=1'b0, HALTED=1'b1.
- One sub-module is natural: fd_reg, the F/D pipeline register with hold/flush controls (d_pc, d_insn, d_valid). fetch_stage holds the PC, the state machine and the counters.

Test Plan:
- Reset, then 4 free-running cycles with imem returning addi words. Required: d_pc sequence 01000000, 01000004, 01000008; d_valid=1 from the 2nd cycle; fetch_count=3 after the 4th edge.
- stall held 3 cycles at pc_f=01000008. Required: imem_addr, d_pc and d_insn frozen; fetch_count unchanged; resumes at 0100000C.
- redirect=1 with target 01000100 and stall=1 in the same cycle. Required: x_flush=1; next cycle d_valid=0, d_insn=00000013, imem_addr=01000100; flush_count=1.
- imem returns 00000073 at 01000010. Required: d_insn=00000073 with d_valid=1; then halted=1, imem_addr stays 01000010, d_valid=0 every cycle. A later redirect to 01000020 clears halted and fetch resumes at 01000020.
- redirect target 01000102. Required: pc_f=01000100 and misalign_err=1, still 1 after 10 cycles; reset clears it.
- Reset asserted during HALTED with counters nonzero. Required: next cycle pc_f=01000000, halted=0, both counters 0, d_valid=0.
